axi_sram_slave: RTL



---
 rtl/axi_sram_slave.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by a word-addressed flop array; one transaction at a time, writes win ties.
// Optional AXI_SRAM_RANGE_CHECK_EN: out-of-range beats are dropped/zeroed and answer SLVERR.
module axi_sram_slave #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 16,
  parameter int DEPTH          = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        aw_valid_i,
  output logic                        aw_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     aw_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   aw_addr_i,
  input  logic [7:0]                  aw_len_i,
  input  logic                        w_valid_i,
  output logic                        w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] w_strb_i,
  input  logic                        w_last_i,
  output logic                        b_valid_o,
  input  logic                        b_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     b_id_o,
  output logic [1:0]                  b_resp_o,
  input  logic                        ar_valid_i,
  output logic                        ar_ready_o,
  input  logic [AXI_ID_WIDTH-1:0]     ar_id_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   ar_addr_i,
  input  logic [7:0]                  ar_len_i,
  output logic                        r_valid_o,
  input  logic                        r_ready_i,
  output logic [AXI_ID_WIDTH-1:0]     r_id_o,
  output logic [AXI_DATA_WIDTH-1:0]   r_data_o,
  output logic [1:0]                  r_resp_o,
  output logic                        r_last_o
);
  localparam int NB      = AXI_DATA_WIDTH / 8;
  localparam int IDX_LSB = $clog2(NB);
  localparam int IW      = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WDATA = 2'd1;
  localparam logic [1:0] S_WRESP = 2'd2;
  localparam logic [1:0] S_RDATA = 2'd3;

  logic [1:0]                state, state_nxt;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                len_q, cnt_q;
  logic [AXI_ID_WIDTH-1:0]   id_q;
  logic                      err_q;
  logic                      aw_hs, ar_hs, w_hs, b_hs, r_hs, last_beat, oor, wr_en;
  logic [IW-1:0]             idx;
  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic                      unused_bits;

  assign aw_hs     = aw_valid_i & aw_ready_o;
  assign ar_hs     = ar_valid_i & ar_ready_o;
  assign w_hs      = w_valid_i & w_ready_o;
  assign b_hs      = b_valid_o & b_ready_i;
  assign r_hs      = r_valid_o & r_ready_i;
  assign last_beat = (cnt_q == len_q);
  assign idx       = addr_q[IDX_LSB +: IW];

`ifdef AXI_SRAM_RANGE_CHECK_EN
  localparam logic [AXI_ADDR_WIDTH:0] LIMIT = (AXI_ADDR_WIDTH+1)'(DEPTH * NB);
  assign oor = ({1'b0, addr_q} >= LIMIT);
`else
  assign oor = 1'b0;
`endif

  // w_last_i is advisory only: the beat counter decides where a burst ends
  assign unused_bits = ^{w_last_i, addr_q};

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (aw_hs) state_nxt = S_WDATA;
               else if (ar_hs) state_nxt = S_RDATA;
      S_WDATA: if (w_hs && last_beat) state_nxt = S_WRESP;
      S_WRESP: if (b_hs) state_nxt = S_IDLE;
      S_RDATA: if (r_hs && last_beat) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake flags are flops decoded from the next state, so they stay low through reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      err_q      <= 1'b0;
      aw_ready_o <= 1'b0;
      ar_ready_o <= 1'b0;
      w_ready_o  <= 1'b0;
      b_valid_o  <= 1'b0;
      r_valid_o  <= 1'b0;
    end else begin
      state      <= state_nxt;
      aw_ready_o <= (state_nxt == S_IDLE);
      ar_ready_o <= (state_nxt == S_IDLE);
      w_ready_o  <= (state_nxt == S_WDATA);
      b_valid_o  <= (state_nxt == S_WRESP);
      r_valid_o  <= (state_nxt == S_RDATA);
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            id_q   <= aw_id_i;
            addr_q <= aw_addr_i;
            len_q  <= aw_len_i;
            cnt_q  <= '0;
            err_q  <= 1'b0;
          end else if (ar_hs) begin
            id_q   <= ar_id_i;
            addr_q <= ar_addr_i;
            len_q  <= ar_len_i;
            cnt_q  <= '0;
          end
        end
        S_WDATA: begin
          if (w_hs) begin
            addr_q <= addr_q + AXI_ADDR_WIDTH'(NB);
            cnt_q  <= cnt_q + 8'd1;
            if (oor) err_q <= 1'b1;
          end
        end
        S_RDATA: begin
          if (r_hs) begin
            addr_q <= addr_q + AXI_ADDR_WIDTH'(NB);
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en = (state == S_WDATA) & w_hs & ~oor;

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < NB; b++)
        if (w_strb_i[b]) mem[idx][b*8 +: 8] <= w_data_i[b*8 +: 8];
    end
  end

  assign b_id_o   = id_q;
  assign r_id_o   = id_q;
  assign b_resp_o = err_q ? 2'b10 : 2'b00;
  assign r_data_o = (r_valid_o && !oor) ? mem[idx] : '0;
  assign r_resp_o = (r_valid_o && oor) ? 2'b10 : 2'b00;
  assign r_last_o = r_valid_o & last_beat;

endmodule
